// File: rtl/prbs_check_pkg.sv
// prbs_pkg: shared PRBS31 state enum, tap positions and next-bit function
package prbs_pkg;
  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;
  localparam int PRBS_W = 31;
  localparam int TAP_A = 30;
  localparam int TAP_B = 27;
  function automatic logic prbs31_next(input logic [PRBS_W-1:0] sr);
    return sr[TAP_A] ^ sr[TAP_B];
  endfunction
endpackage

// File: rtl/prbs_check_if.sv
// prbs_check_if: receive bit stream in, lock status and BER counters out
interface prbs_check_if #(parameter int CNT_W = 32);
  logic bit_in;
  logic valid_in;
  logic clear_cnt;
  logic locked;
  logic err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
  modport master(output bit_in, valid_in, clear_cnt, input locked, err_pulse, err_count, bit_count);
  modport slave(input bit_in, valid_in, clear_cnt, output locked, err_pulse, err_count, bit_count);
endinterface

// File: rtl/prbs_check_sat_counter.sv
// sat_counter: saturating up-counter, clr beats inc
module sat_counter #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  input logic inc,
  input logic clr,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/prbs_check.sv
// prbs_check: self-synchronising PRBS31 checker with windowed loss-of-lock and BER counters
module prbs_check import prbs_pkg::*; #(
  parameter int LOCK_COUNT = 64,
  parameter int ERR_WINDOW = 256,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  prbs_check_if.slave bus
);
  localparam int MW = $clog2(LOCK_COUNT);
  localparam int WW = $clog2(ERR_WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam int FW = $clog2(PRBS_W);
  state_t state;
  logic [PRBS_W-1:0] sr;
  logic [FW-1:0] fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic pred, mis, run, hit, lose;
  always_comb begin
    pred = prbs31_next(sr);
    mis = bus.bit_in ^ pred;
    run = bus.valid_in && state == LOCKED;
    hit = run && mis;
    lose = hit && win_err == EW'(ERR_THRESH - 1);
  end
  // once locked the register free-runs on its own prediction, so a line error is seen exactly once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      sr <= '0;
      fill_cnt <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
      bus.locked <= 1'b0;
      bus.err_pulse <= 1'b0;
    end else begin
      bus.err_pulse <= hit;
      if (bus.valid_in)
        case (state)
          FILL: begin
            sr <= {sr[PRBS_W-2:0], bus.bit_in};
            fill_cnt <= fill_cnt + FW'(1);
            if (fill_cnt == FW'(PRBS_W - 1)) begin
              state <= VERIFY;
              match_cnt <= '0;
            end
          end
          VERIFY: begin
            sr <= {sr[PRBS_W-2:0], bus.bit_in};
            if (mis || sr == '0) match_cnt <= '0;
            else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state <= LOCKED;
              bus.locked <= 1'b1;
              win_cnt <= '0;
              win_err <= '0;
            end else match_cnt <= match_cnt + MW'(1);
          end
          default: begin
            sr <= {sr[PRBS_W-2:0], pred};
            if (lose) begin
              state <= FILL;
              fill_cnt <= '0;
              bus.locked <= 1'b0;
            end else if (win_cnt == WW'(ERR_WINDOW - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              win_err <= win_err + EW'(mis);
            end
          end
        endcase
    end
  end
  sat_counter #(.WIDTH(CNT_W)) u_err (.clk(clk), .rst_n(rst_n), .inc(hit), .clr(bus.clear_cnt), .count(bus.err_count));
  sat_counter #(.WIDTH(CNT_W)) u_bit (.clk(clk), .rst_n(rst_n), .inc(run), .clr(bus.clear_cnt), .count(bus.bit_count));
endmodule
